uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BASEADDR, default 16'h0010: first byte address of the 5-byte register window.
REQ-002 SHALL have parameter FIFODEPTH, default 8: TX FIFO depth in bytes, a power of two from 2 to 16.
REQ-003 SHALL have parameter DIVRESET, default 16'd103: reset value of DIVISOR.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port dread_addr, input, 16 bits: data-bus read byte address.
REQ-007 SHALL have port dread_data, output, 16 bits: read data, registered; low byte = addr, high byte = addr+1.
REQ-008 SHALL have port dwrite_addr, input, 16 bits: data-bus write byte address.
REQ-009 SHALL have port dwrite_data, input, 16 bits: write data; low byte to addr, high byte to addr+1.
REQ-010 SHALL have port dwrite_en, input, 2 bits: bit0 enables the low-byte write, bit1 enables the high-byte write.
REQ-011 SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-013 Register map, offsets from BASEADDR:
- +0 DATA: W pushes byte; R 0x00.
- +1 STATUS: R = {level[3:0], overrun, busy, empty, full}; W: bit3=1 clears overrun, other bits ignored.
- +2 DIVLO, +3 DIVHI: DIVISOR[15:0], R/W.
- +4 CTRL: bit0 txen, bit1 irqen, R/W; bits 7:2 read 0.
REQ-014 Each byte lane SHALL decode independently; an address outside the window SHALL read 0x00, and writes to it SHALL be ignored.
REQ-015 dread_data SHALL reflect the state at the clock edge that samples dread_addr, valid the following cycle; reads SHALL have no side effects.
REQ-016 A DATA write when not full SHALL push the byte; a DATA write when full SHALL drop the byte and set overrun, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-017 A simultaneous overrun set and W1C clear SHALL leave overrun set.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP; txd SHALL be 1 in IDLE and STOP, 0 in START, and the shift-register LSB in DATA.
REQ-019 IDLE -> START when txen=1 and the FIFO is non-empty; the FIFO head SHALL be popped into the shift register on that edge.
REQ-020 Each state-bit SHALL last DIVISOR+1 clocks; the down-counter SHALL load DIVISOR at each bit start, so a DIVISOR write mid-bit takes effect at the next bit.
REQ-021 DATA SHALL send 8 bits LSB first, counted by a 3-bit counter, then go to STOP.
REQ-022 At the end of STOP, the FSM SHALL go to START with a pop if txen=1 and the FIFO is non-empty (no idle gap), else to IDLE.
REQ-023 Clearing txen mid-frame SHALL complete the current frame, then stop in IDLE.
REQ-024 Latency: a DATA write captured at edge E into an empty FIFO in IDLE SHALL pop at edge E+1, with txd low from E+1; frame length SHALL be 10*(DIVISOR+1) clocks.
REQ-025 busy SHALL be 1 whenever the state is not IDLE.
REQ-026 level SHALL be 0..FIFODEPTH, saturating in the nibble (FIFODEPTH 16 reads 0xF when full); empty SHALL mean level==0 and full SHALL mean level==FIFODEPTH.
REQ-027 irq SHALL equal irqen & empty & ~busy, combinational from registered state.
REQ-028 DIVISOR=0 SHALL give 1 clock per bit.

Reset
REQ-029 On reset low, and asynchronously, the following SHALL take these values: state IDLE, txd=1, FIFO empty with pointers 0, overrun=0, txen=0, irqen=0, DIVISOR=DIVRESET, dread_data=0, irq=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with txd=1 and discard FIFO contents.

Structure
REQ-031 Register offsets, STATUS bit positions and the FSM state enum SHALL reside in a shared package uart_pkg.
REQ-032 The FIFO SHALL be one sub-module, uart_fifo (push, pop, data, level, full, empty), parameterised by depth and width.
REQ-033 The block SHALL be a pure data-bus responder with no combinational path from dread_addr to dread_data.

Verification
REQ-034 Bench SHALL check: after reset, STATUS read = 0x02, DIVLO/DIVHI = 0x67/0x00, txd=1, irq=0.
REQ-035 Bench SHALL check: DIVISOR=3, txen=1, write 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1, 4 clocks each, 40 clocks total, then busy=0.
REQ-036 Bench SHALL check: 9 DATA writes with txen=0 -> STATUS = 0x89 (level 8, overrun, full); write STATUS 0x08 -> 0x81.
REQ-037 Bench SHALL check: two bytes queued, DIVISOR=0 -> 20 contiguous bit clocks with no idle cycle between the frames.
REQ-038 Bench SHALL check: irqen=1, one byte sent -> irq rises the cycle after STOP ends; a word write of 0x0203 to +3/+4 sets DIVHI=0x03 and CTRL=0x02.
REQ-039 Bench SHALL check: reset low in DATA state -> txd=1, STATUS=0x02 in the same cycle, with no further frame after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register offsets, STATUS/CTRL
// bit positions, FSM state encoding and the level-nibble helper.
package uart_pkg;

    // Byte offsets from the window base address
    localparam logic [2:0]  OffData   = 3'd0;
    localparam logic [2:0]  OffStatus = 3'd1;
    localparam logic [2:0]  OffDivLo  = 3'd2;
    localparam logic [2:0]  OffDivHi  = 3'd3;
    localparam logic [2:0]  OffCtrl   = 3'd4;
    localparam logic [15:0] WinSize   = 16'd5;

    // STATUS bit positions; level occupies bits 7:4
    localparam int unsigned StatusFull     = 0;
    localparam int unsigned StatusEmpty    = 1;
    localparam int unsigned StatusBusy     = 2;
    localparam int unsigned StatusOverrun  = 3;
    localparam int unsigned StatusLevelLsb = 4;

    // CTRL bit positions
    localparam int unsigned CtrlTxen  = 0;
    localparam int unsigned CtrlIrqen = 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // A 16-deep FIFO can hold 16 bytes; the nibble saturates at 0xF
    function automatic logic [3:0] level_nibble(input logic [4:0] level);
        return (level > 5'd15) ? 4'hF : level[3:0];
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the TX path. A push into a full FIFO is accepted only
// when a pop happens on the same edge; the head is presented combinationally.
module uart_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned LvlW  = AddrW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic [LvlW-1:0]  level,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q;
    logic [AddrW-1:0] rptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LvlW'(Depth));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];
    assign level   = level_q;

    // Storage array; contents need no reset since the pointers gate every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap freely
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AddrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a byte-addressed 5-register window on a 16-bit data bus:
// TX FIFO, programmable bit divisor, 8N1 framing and a level interrupt.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [15:0] BASEADDR  = 16'h0010,
    parameter int unsigned FIFODEPTH = 8,
    parameter logic [15:0] DIVRESET  = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        txd,
    output logic        irq
);

    localparam int unsigned LvlW = $clog2(FIFODEPTH) + 1;

    // Control/status registers
    logic [15:0] div_q;
    logic        txen_q;
    logic        irqen_q;
    logic        ovr_q;

    // Transmit engine
    tx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        txd_q;
    logic        bit_done;

    // FIFO interface
    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_wdata;
    logic [7:0]      fifo_rdata;
    logic [LvlW-1:0] fifo_level;
    logic            fifo_full;
    logic            fifo_empty;

    // Write decode results
    logic [15:0] wr_off [2];
    logic        ovr_clr;
    logic        ovr_set;
    logic        divlo_we;
    logic        divhi_we;
    logic        ctrl_we;
    logic [7:0]  divlo_wd;
    logic [7:0]  divhi_wd;
    logic [7:0]  ctrl_wd;

    logic [7:0]  status;
    logic        busy;

    uart_fifo #(
        .Depth (FIFODEPTH),
        .Width (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy     = (state_q != StIdle);
    assign bit_done = (cnt_q == '0);
    assign txd      = txd_q;
    assign irq      = irqen_q & fifo_empty & ~busy;

    assign wr_off[0] = dwrite_addr - BASEADDR;
    assign wr_off[1] = dwrite_addr + 16'd1 - BASEADDR;

    // Returns the register byte at a bus address, 0x00 outside the window
    function automatic logic [7:0] read_byte(input logic [15:0] addr,
                                             input logic [7:0]  stat,
                                             input logic [15:0] div,
                                             input logic [1:0]  ctrl);
        logic [15:0] off;
        off = addr - BASEADDR;
        read_byte = 8'h00;
        if (off < WinSize) begin
            case (off[2:0])
                OffStatus: read_byte = stat;
                OffDivLo:  read_byte = div[7:0];
                OffDivHi:  read_byte = div[15:8];
                OffCtrl:   read_byte = {6'b0, ctrl};
                default:   read_byte = 8'h00;
            endcase
        end
    endfunction

    // Assemble the STATUS byte from live state
    always_comb begin
        status                         = '0;
        status[StatusFull]             = fifo_full;
        status[StatusEmpty]            = fifo_empty;
        status[StatusBusy]             = busy;
        status[StatusOverrun]          = ovr_q;
        status[StatusLevelLsb +: 4]    = level_nibble(5'(fifo_level));
    end

    // Decode both write lanes independently into per-register strobes
    always_comb begin
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        ovr_clr    = 1'b0;
        divlo_we   = 1'b0;
        divhi_we   = 1'b0;
        ctrl_we    = 1'b0;
        divlo_wd   = '0;
        divhi_wd   = '0;
        ctrl_wd    = '0;
        for (int i = 0; i < 2; i++) begin
            if (dwrite_en[i] && (wr_off[i] < WinSize)) begin
                case (wr_off[i][2:0])
                    OffData: begin
                        fifo_push  = 1'b1;
                        fifo_wdata = dwrite_data[8*i +: 8];
                    end
                    OffStatus: ovr_clr = dwrite_data[8*i + StatusOverrun];
                    OffDivLo: begin
                        divlo_we = 1'b1;
                        divlo_wd = dwrite_data[8*i +: 8];
                    end
                    OffDivHi: begin
                        divhi_we = 1'b1;
                        divhi_wd = dwrite_data[8*i +: 8];
                    end
                    OffCtrl: begin
                        ctrl_we = 1'b1;
                        ctrl_wd = dwrite_data[8*i +: 8];
                    end
                    default: ;
                endcase
            end
        end
    end

    // A push into a full FIFO is lost unless the engine pops on the same edge
    assign ovr_set = fifo_push && fifo_full && !fifo_pop;

    // Pop whenever a new frame can start: from idle, or straight out of a finished stop bit
    always_comb begin
        fifo_pop = 1'b0;
        if (txen_q && !fifo_empty) begin
            if (state_q == StIdle) begin
                fifo_pop = 1'b1;
            end else if ((state_q == StStop) && bit_done) begin
                fifo_pop = 1'b1;
            end
        end
    end

    // Register file updates; overrun set wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= DIVRESET;
            txen_q  <= 1'b0;
            irqen_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (divlo_we) begin
                div_q[7:0] <= divlo_wd;
            end
            if (divhi_we) begin
                div_q[15:8] <= divhi_wd;
            end
            if (ctrl_we) begin
                txen_q  <= ctrl_wd[CtrlTxen];
                irqen_q <= ctrl_wd[CtrlIrqen];
            end
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Registered read port: both lanes sample state before this edge's updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dread_data <= '0;
        end else begin
            dread_data <= {read_byte(dread_addr + 16'd1, status, div_q, {irqen_q, txen_q}),
                           read_byte(dread_addr, status, div_q, {irqen_q, txen_q})};
        end
    end

    // Frame engine: each bit lasts div_q+1 clocks, divisor sampled at every bit start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        state_q <= StStart;
                        shift_q <= fifo_rdata;
                        cnt_q   <= div_q;
                        txd_q   <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        state_q <= StData;
                        cnt_q   <= div_q;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        cnt_q <= div_q;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        if (fifo_pop) begin
                            state_q <= StStart;
                            shift_q <= fifo_rdata;
                            cnt_q   <= div_q;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bytes written to DATA are queued as expected
// frames and compared bit-by-bit, clock-by-clock against txd.
module tb_uart_tx;

    localparam logic [15:0] AData   = 16'h0010;
    localparam logic [15:0] AStatus = 16'h0011;
    localparam logic [15:0] ADivLo  = 16'h0012;
    localparam logic [15:0] ADivHi  = 16'h0013;
    localparam logic [15:0] ACtrl   = 16'h0014;

    logic        clk;
    logic        reset;
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;
    logic        txd;
    logic        irq;

    int tests_run;
    int tests_failed;
    logic [7:0] sb [$];

    uart_tx #(
        .BASEADDR  (16'h0010),
        .FIFODEPTH (8),
        .DIVRESET  (16'd103)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .txd         (txd),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // All bus tasks start and end on a negedge
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data,
                             input logic [1:0] en);
        dwrite_addr = addr;
        dwrite_data = data;
        dwrite_en   = en;
        @(negedge clk);
        dwrite_en   = 2'b00;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        dread_addr = addr;
        @(negedge clk);
        data = dread_data;
    endtask

    task automatic push_byte(input logic [7:0] b);
        sb.push_back(b);
        bus_write(AData, {8'h00, b}, 2'b01);
    endtask

    // Checks txd on every clock of nframes back-to-back frames, starting next clock
    task automatic rx_frames(input int div, input int nframes);
        logic [7:0] exp;
        logic [9:0] bits;
        for (int f = 0; f < nframes; f++) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL rx_scoreboard: got empty queue, expected a pending byte");
                return;
            end
            exp  = sb.pop_front();
            bits = {1'b1, exp, 1'b0};
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c <= div; c++) begin
                    @(negedge clk);
                    tests_run++;
                    if (txd !== bits[b]) begin
                        tests_failed++;
                        $display("FAIL rx_bit byte=%h bit=%0d clk=%0d: got txd=%b expected %b",
                                 exp, b, c, txd, bits[b]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (txd !== 1'b1 || irq !== 1'b0 || dread_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got txd=%b irq=%b rd=%h expected 1 0 0000",
                     txd, irq, dread_data);
        end
        reset = 1'b1;
        @(negedge clk);
        bus_read(AStatus, rd);
        tests_run++;
        if (rd[7:0] !== 8'h02) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 02", rd[7:0]);
        end
        bus_read(ADivLo, rd);
        tests_run++;
        if (rd !== 16'h0067) begin
            tests_failed++;
            $display("FAIL reset_divisor: got %h expected 0067", rd);
        end
        bus_read(16'h000F, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL read_below_window: got %h expected 0000", rd);
        end
    endtask

    task automatic test_frame_a5;
        logic [15:0] rd;
        bus_write(ADivLo, 16'h0003, 2'b11);
        bus_write(ACtrl, 16'h0001, 2'b01);
        push_byte(8'hA5);
        // Pop happens on the edge after the write, so txd is still idle here
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL a5_latency: got txd=%b expected 1", txd);
        end
        rx_frames(3, 1);
        @(negedge clk);
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL a5_after_stop: got txd=%b expected 1", txd);
        end
        bus_read(AStatus, rd);
        tests_run++;
        if (rd[7:0] !== 8'h02) begin
            tests_failed++;
            $display("FAIL a5_not_busy: got status %h expected 02", rd[7:0]);
        end
    endtask

    task automatic test_overrun;
        logic [15:0] rd;
        bus_write(ACtrl, 16'h0000, 2'b01);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                push_byte(8'h30 + 8'(i));
            end else begin
                bus_write(AData, 16'h00EE, 2'b01);
            end
        end
        bus_read(AStatus, rd);
        tests_run++;
        if (rd[7:0] !== 8'h89) begin
            tests_failed++;
            $display("FAIL overrun_status: got %h expected 89", rd[7:0]);
        end
        bus_write(AStatus, 16'h0008, 2'b01);
        bus_read(AStatus, rd);
        tests_run++;
        if (rd[7:0] !== 8'h81) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %h expected 81", rd[7:0]);
        end
        // Drain at one clock per bit; the dropped byte must never appear
        bus_write(ADivLo, 16'h0000, 2'b11);
        bus_write(ACtrl, 16'h0001, 2'b01);
        rx_frames(0, 8);
        @(negedge clk);
        bus_read(AStatus, rd);
        tests_run++;
        if (rd[7:0] !== 8'h02) begin
            tests_failed++;
            $display("FAIL drain_status: got %h expected 02", rd[7:0]);
        end
    endtask

    task automatic test_back_to_back;
        bus_write(ACtrl, 16'h0000, 2'b01);
        push_byte(8'h81);
        push_byte(8'h7E);
        bus_write(ACtrl, 16'h0001, 2'b01);
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle_before: got txd=%b expected 1", txd);
        end
        rx_frames(0, 2);
    endtask

    task automatic test_irq;
        logic [15:0] rd;
        bus_write(ADivLo, 16'h0001, 2'b11);
        bus_write(ACtrl, 16'h0003, 2'b01);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_idle_empty: got %b expected 1", irq);
        end
        push_byte(8'h3C);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_after_push: got %b expected 0", irq);
        end
        rx_frames(1, 1);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_during_stop: got %b expected 0", irq);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_after_stop: got %b expected 1", irq);
        end
        bus_write(ADivHi, 16'h0203, 2'b11);
        bus_read(ADivHi, rd);
        tests_run++;
        if (rd !== 16'h0203) begin
            tests_failed++;
            $display("FAIL word_write_divhi_ctrl: got %h expected 0203", rd);
        end
        bus_read(ADivLo, rd);
        tests_run++;
        if (rd !== 16'h0301) begin
            tests_failed++;
            $display("FAIL divisor_lanes: got %h expected 0301", rd);
        end
        // High lane lands outside the window and must be ignored
        bus_write(ACtrl, 16'hFF02, 2'b11);
        bus_read(ACtrl, rd);
        tests_run++;
        if (rd !== 16'h0002) begin
            tests_failed++;
            $display("FAIL ctrl_window_edge: got %h expected 0002", rd);
        end
        bus_write(ADivHi, 16'h0000, 2'b01);
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] rd;
        int bad;
        bus_write(ADivLo, 16'h0003, 2'b11);
        bus_write(ACtrl, 16'h0001, 2'b01);
        bus_write(AData, 16'h0000, 2'b01);
        bus_write(AData, 16'h0055, 2'b01);
        // Start bit covers four clocks, then data bit 0 (a zero) is on the line
        repeat (6) @(negedge clk);
        tests_run++;
        if (txd !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_frame_data_bit: got txd=%b expected 0", txd);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (txd !== 1'b1 || irq !== 1'b0 || dread_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset: got txd=%b irq=%b rd=%h expected 1 0 0000",
                     txd, irq, dread_data);
        end
        @(negedge clk);
        reset = 1'b1;
        bus_read(AStatus, rd);
        tests_run++;
        if (rd[7:0] !== 8'h02) begin
            tests_failed++;
            $display("FAIL reset_discard_status: got %h expected 02", rd[7:0]);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL no_frame_after_reset: got %0d low samples expected 0", bad);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        dread_addr   = '0;
        dwrite_addr  = '0;
        dwrite_data  = '0;
        dwrite_en    = 2'b00;
        @(negedge clk);
        test_reset();
        test_frame_a5();
        test_overrun();
        test_back_to_back();
        test_irq();
        test_reset_mid_frame();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drained: got %0d left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
